// File: rtl/enemy_spawner.sv
`default_nettype none
// ============================================================================
// Module      : enemy_spawner
// Description : Game-control stage feeding the enemy sprite renderer. Runs the
//               play state machine, picks a pseudo-random grid cell (1-9) for
//               each enemy, times its visibility, judges key strikes and keeps
//               score / miss counters for the HUD.
// Ports       : clk_i        - system clock
//               rst_ni       - asynchronous active-low reset
//               start_i      - single-cycle pulse, starts/restarts the game
//               key_valid_i  - single-cycle strike strobe
//               key_pos_i    - struck cell (1-9, other values never match)
//               pos_o        - current enemy cell, 0 = no enemy
//               hit_o        - enemy at pos_o was struck (renderer blanks it)
//               score_o      - successful strikes, saturating at 255
//               miss_o       - timed-out enemies, saturating at MAX_MISS
//               game_over_o  - high while the game is over
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_spawner #(
  parameter int GAP_CYC  = 25_000_000,
  parameter int LIFE_CYC = 50_000_000,
  parameter int HIT_CYC  = 12_500_000,
  parameter int MAX_MISS = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_pos_i,
  output logic [3:0] pos_o,
  output logic       hit_o,
  output logic [7:0] score_o,
  output logic [3:0] miss_o,
  output logic       game_over_o
);

  localparam logic [25:0] GAP_LOAD  = 26'(GAP_CYC - 1);
  localparam logic [25:0] LIFE_LOAD = 26'(LIFE_CYC - 1);
  localparam logic [25:0] HIT_LOAD  = 26'(HIT_CYC - 1);
  localparam logic [3:0]  MISS_LIM  = 4'(MAX_MISS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GAP     = 3'd1,
    S_ACTIVE  = 3'd2,
    S_HITSHOW = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  pos_q, pos_d;
  logic        hit_q, hit_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  miss_q, miss_d;
  logic        over_q, over_d;

  logic [3:0]  cand;
  logic [3:0]  spawn;
  logic [3:0]  miss_inc;

  // Spawn cell: (lfsr mod 9) + 1, bumped by one (9 wraps to 1) when it would
  // repeat the previous enemy's cell.
  always_comb begin
    cand     = 4'(lfsr_q % 8'd9) + 4'd1;
    spawn    = cand;
    if (cand == prev_q) begin
      spawn = (cand == 4'd9) ? 4'd1 : cand + 4'd1;
    end
    miss_inc = miss_q + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    hit_d   = hit_q;
    score_d = score_q;
    miss_d  = miss_q;
    over_d  = over_q;
    // Free-running LFSR: the player's timing decides which value gets used.
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    unique case (state_q)
      S_IDLE, S_OVER: begin
        pos_d = 4'd0;
        hit_d = 1'b0;
        if (start_i) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
          score_d = 8'd0;
          miss_d  = 4'd0;
          over_d  = 1'b0;
        end
      end
      S_GAP: begin
        if (cnt_q == 26'd0) begin
          state_d = S_ACTIVE;
          pos_d   = spawn;
          prev_d  = spawn;
          cnt_d   = LIFE_LOAD;
        end else begin
          cnt_d = cnt_q - 26'd1;
        end
      end
      S_ACTIVE: begin
        // A matching strike wins over a simultaneous timeout.
        if (key_valid_i && (key_pos_i == pos_q)) begin
          state_d = S_HITSHOW;
          hit_d   = 1'b1;
          cnt_d   = HIT_LOAD;
          if (score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end
        end else if (cnt_q == 26'd0) begin
          miss_d = miss_inc;
          pos_d  = 4'd0;
          if (miss_inc == MISS_LIM) begin
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 26'd1;
        end
      end
      S_HITSHOW: begin
        if (cnt_q == 26'd0) begin
          state_d = S_GAP;
          pos_d   = 4'd0;
          hit_d   = 1'b0;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 26'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 26'd0;
        pos_d   = 4'd0;
        hit_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 26'd0;
      lfsr_q  <= 8'hA5;
      prev_q  <= 4'd0;
      pos_q   <= 4'd0;
      hit_q   <= 1'b0;
      score_q <= 8'd0;
      miss_q  <= 4'd0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      over_q  <= over_d;
    end
  end

  assign pos_o       = pos_q;
  assign hit_o       = hit_q;
  assign score_o     = score_q;
  assign miss_o      = miss_q;
  assign game_over_o = over_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_spawner
// Description : Self-checking bench for enemy_spawner. A phase/remaining-time
//               game model pushes the expected outputs after every clock edge
//               into a queue; a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_spawner;

  localparam int GAP  = 4;
  localparam int LIFE = 8;
  localparam int HITC = 3;
  localparam int MAXM = 3;

  localparam int P_IDLE = 0;
  localparam int P_GAP  = 1;
  localparam int P_ACT  = 2;
  localparam int P_HIT  = 3;
  localparam int P_OVER = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_pos = 4'd0;
  logic [3:0] pos;
  logic       hit;
  logic [7:0] score;
  logic [3:0] miss;
  logic       game_over;

  enemy_spawner #(
    .GAP_CYC (GAP),
    .LIFE_CYC(LIFE),
    .HIT_CYC (HITC),
    .MAX_MISS(MAXM)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .key_valid_i(key_valid),
    .key_pos_i  (key_pos),
    .pos_o      (pos),
    .hit_o      (hit),
    .score_o    (score),
    .miss_o     (miss),
    .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pos;
    logic       hit;
    logic [7:0] score;
    logic [3:0] miss;
    logic       over;
  } exp_t;

  exp_t expq[$];
  exp_t e_mon;
  exp_t a_mon;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (game phases, cycles remaining) -------
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_cell  = 0;
  int m_prev  = 0;
  int m_score = 0;
  int m_miss  = 0;
  int m_hit   = 0;
  int m_over  = 0;
  int m_lfsr  = 'hA5;

  function automatic int spawn_cell(input int l, input int prev);
    int c;
    c = (l % 9) + 1;
    if (c == prev) c = (c % 9) + 1;
    return c;
  endfunction

  function automatic int lfsr_step(input int l);
    int fb;
    fb = $countones(l & 'hB8) % 2;
    return ((l << 1) | fb) & 255;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_left = 0; m_cell = 0; m_prev = 0;
      m_score = 0; m_miss = 0; m_hit = 0; m_over = 0; m_lfsr = 'hA5;
      expq.delete();
    end else begin
      case (m_phase)
        P_IDLE, P_OVER: begin
          if (start) begin
            m_phase = P_GAP; m_left = GAP;
            m_score = 0; m_miss = 0; m_over = 0;
          end
        end
        P_GAP: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_cell  = spawn_cell(m_lfsr, m_prev);
            m_prev  = m_cell;
            m_phase = P_ACT;
            m_left  = LIFE;
          end
        end
        P_ACT: begin
          if (key_valid && (int'(key_pos) == m_cell)) begin
            m_phase = P_HIT; m_hit = 1; m_left = HITC;
            if (m_score < 255) m_score = m_score + 1;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_miss = m_miss + 1;
              m_cell = 0;
              if (m_miss == MAXM) begin
                m_phase = P_OVER; m_over = 1;
              end else begin
                m_phase = P_GAP; m_left = GAP;
              end
            end
          end
        end
        P_HIT: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_phase = P_GAP; m_cell = 0; m_hit = 0; m_left = GAP;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      m_lfsr = lfsr_step(m_lfsr);
      expq.push_back({4'(m_cell), 1'(m_hit), 8'(m_score), 4'(m_miss), 1'(m_over)});
    end
  end

  // ---------------- monitor ------------------------------------------------
  int last_pos = 0;
  int last_spawn = 0;
  int spawns = 0;
  bit seen [1:9];

  always @(negedge clk) begin
    if (!rst_n) begin
      last_pos = 0; last_spawn = 0; spawns = 0;
      for (int i = 1; i <= 9; i++) seen[i] = 1'b0;
    end else begin
      if (expq.size() > 0) begin
        e_mon = expq.pop_front();
        a_mon = {pos, hit, score, miss, game_over};
        checks++;
        if (a_mon !== e_mon) begin
          errors++;
          $display("FAIL outputs t=%0t: got pos=%0d hit=%0d score=%0d miss=%0d over=%0d, expected pos=%0d hit=%0d score=%0d miss=%0d over=%0d",
                   $time, pos, hit, score, miss, game_over,
                   e_mon.pos, e_mon.hit, e_mon.score, e_mon.miss, e_mon.over);
        end
      end
      if (pos != 4'd0 && last_pos == 0) begin
        spawns++;
        checks++;
        if (pos > 4'd9 || int'(pos) == last_spawn) begin
          errors++;
          $display("FAIL spawn_cell: got %0d, required 1..9 and not previous %0d", pos, last_spawn);
        end
        if (pos >= 4'd1 && pos <= 4'd9) seen[int'(pos)] = 1'b1;
        last_spawn = int'(pos);
      end
      last_pos = int'(pos);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic drive(input bit s, input bit kv, input logic [3:0] kp);
    start = s; key_valid = kv; key_pos = kp;
    @(posedge clk); #1;
    start = 1'b0; key_valid = 1'b0; key_pos = 4'd0;
  endtask

  task automatic wait_phase(input int ph, input int lim, input string nm);
    int n = 0;
    while (m_phase != ph && n < lim) begin
      drive(1'b0, 1'b0, 4'd0);
      n++;
    end
    if (m_phase != ph) begin
      checks++; errors++;
      $display("FAIL wait_%s: phase %0d after %0d cycles, required %0d", nm, m_phase, n, ph);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Strikes while idle are ignored.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));

    // Full timeline of one unstruck enemy.
    drive(1'b1, 1'b0, 4'd0);
    repeat (14) drive(1'b0, 1'b0, 4'd0);

    // Correct strike during ACTIVE.
    wait_phase(P_ACT, 40, "active1");
    drive(1'b0, 1'b1, 4'(m_cell));
    repeat (5) drive(1'b0, 1'b0, 4'd0);

    // Wrong cell first, then correct strike on the last ACTIVE cycle.
    wait_phase(P_ACT, 40, "active2");
    drive(1'b0, 1'b1, 4'((m_cell % 9) + 1));
    n = 0;
    while (!(m_phase == P_ACT && m_left == 1) && n < 40) begin
      drive(1'b0, 1'b0, 4'd0);
      n++;
    end
    drive(1'b0, 1'b1, 4'(m_cell));
    repeat (4) drive(1'b0, 1'b0, 4'd0);

    // Asynchronous reset in the middle of an ACTIVE enemy.
    wait_phase(P_ACT, 40, "active3");
    check_val("pre_reset_score", int'(score), 2);
    check_val("pre_reset_pos_nonzero", int'(pos != 4'd0), 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_reset_pos", int'(pos), 0);
    check_val("async_reset_hit", int'(hit), 0);
    check_val("async_reset_score", int'(score), 0);
    check_val("async_reset_miss", int'(miss), 0);
    check_val("async_reset_over", int'(game_over), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) drive(1'b0, 1'b0, 4'd0);

    // Three timeouts in a row; strikes outside ACTIVE and start pulses ignored.
    drive(1'b1, 1'b0, 4'd0);
    n = 0;
    while (m_phase != P_OVER && n < 200) begin
      drive(($urandom % 4) == 0, (m_phase != P_ACT) && (($urandom % 2) == 0),
            4'($urandom_range(1, 9)));
      n++;
    end
    check_val("reached_over", m_phase, P_OVER);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    drive(1'b1, 1'b0, 4'd0);
    repeat (6) drive(1'b0, 1'b0, 4'd0);

    // Long randomized play until 200 spawns have been observed.
    n = 0;
    while (spawns < 200 && n < 20000) begin
      if (m_phase == P_ACT && ($urandom % 6) == 0)
        drive(($urandom % 10) == 0, 1'b1, 4'(m_cell));
      else
        drive(($urandom % 10) == 0, ($urandom % 5) == 0, 4'($urandom_range(0, 15)));
      n++;
    end
    check_val("spawn_count_reached", int'(spawns >= 200), 1);
    for (int i = 1; i <= 9; i++) check_val($sformatf("cell_%0d_seen", i), int'(seen[i]), 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
